mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares the single external instruction/data memory port (8-bit address, 15-bit read word, 8-bit write byte, write strobe) between two requesters: the processor core and a host loader/debug port.
- Host has priority. A starvation counter guarantees core progress, and a halt input can lock the core out while a program image is loaded.
- Sits between the top-level memory pins and the core's address/write-data outputs.

Parameters:
- ADDR_W, 8, memory address width.
- RDATA_W, 15, memory read word width (instruction word).
- WDATA_W, 8, memory write data width.
- MAX_WAIT, 4, consecutive denied core-request cycles before the core is forced a grant (1..15).

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset_n  in  1  reset; one clock; reset is asynchronous and active-low.
- core_req  in  1  core requests an access; held with core_we/adr/wdata until core_gnt.
- core_we  in  1  1 = write, 0 = read.
- core_adr  in  ADDR_W  core access address.
- core_wdata  in  WDATA_W  core write data.
- core_gnt  out  1  combinational; request accepted at this clock edge.
- core_rvalid  out  1  read data for the core's oldest accepted read is on rdata.
- host_req, host_we, host_adr, host_wdata  in  1/1/ADDR_W/WDATA_W  same semantics as the core_* inputs, for the host.
- host_gnt  out  1  combinational grant to the host.
- host_rvalid  out  1  read data for the host is on rdata.
- dbg_halt  in  1  1 = core is never granted.
- rdata  out  RDATA_W  registered copy of mem_rdata, shared by both requesters.
- mem_adr  out  ADDR_W  registered memory address.
- mem_we  out  1  registered write strobe.
- mem_wdata  out  WDATA_W  registered write data.
- mem_rdata  in  RDATA_W  memory read data, valid the cycle after mem_adr is presented with mem_we=0.

Behaviour:
- Grant logic is combinational, from the requests and the registered state; at most one grant per cycle.
  - Only one requester active: that requester wins.
  - Both active: host wins unless wait_cnt == MAX_WAIT; then the core wins.
  - dbg_halt=1: core_gnt is forced 0 regardless.
- wait_cnt (4 bits):
  - Increments when core_req=1, dbg_halt=0 and core_gnt=0.
  - Clears on core_gnt, or on core_req=0 or dbg_halt=1.
  - Saturates at MAX_WAIT.
- Cycle N: gnt=1, so the request is captured at the edge.
- Cycle N+1:
  - mem_adr/mem_we/mem_wdata hold the captured request.
  - owner register = CORE or HOST.
  - mem_we is high exactly one cycle per granted write.
- Cycle N+2, reads only:
  - rdata = mem_rdata sampled at the end of N+1.
  - The rvalid of the captured owner pulses 1 cycle.
  - Writes produce no rvalid.
- Owner state: OWN_NONE, OWN_CORE, OWN_HOST.
  - Next state = winner of the current cycle, or OWN_NONE if no grant.
  - A second 1-bit stage (rd_owner) tracks which requester the outstanding read belongs to.
- Throughput: one access per cycle, back-to-back and interleaved; read responses return in grant order.
- With no grant in a cycle: mem_we=0 next cycle, and mem_adr/mem_wdata hold their previous value.
- Reset values (asynchronous, while reset_n=0):
  - mem_adr=0, mem_we=0, mem_wdata=0, rdata=0.
  - core_rvalid=0, host_rvalid=0.
  - owner=OWN_NONE, rd_owner cleared, wait_cnt=0.
  - gnt outputs=0 while reset_n=0.
- Reset mid-operation: in-flight reads are dropped (no rvalid after release); an in-flight write is cut (mem_we falls immediately).
- Simultaneous requests with dbg_halt=1 and the counter saturated: host wins and the counter clears.
- A requester may drop req without a grant; no state is retained for it.

Decomposition:
- Package mem_arb_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_CORE, OWN_HOST}.
  - Default width constants ADDR_W/RDATA_W/WDATA_W.
  - Localparam WAIT_W=4.
- Sub-module mem_arb_starve_ctr:
  - Saturating wait counter.
  - Inputs: core_req, core_gnt, dbg_halt.
  - Output: force_core.

Test Plan:
- Core-only read at 0x10, mem_rdata=0x1234:
  - core_gnt=1 in cycle 0.
  - mem_adr=0x10, mem_we=0 in cycle 1.
  - core_rvalid=1, rdata=0x1234 in cycle 2.
  - host_rvalid stays 0.
- Both requesters held high for 15 cycles, MAX_WAIT=4:
  - Grant pattern H,H,H,H,C repeated 3 times.
  - wait_cnt returns to 0 after each core grant.
- Host write at 0xFF, data 0xA5:
  - mem_we=1 for exactly one cycle with mem_adr=0xFF, mem_wdata=0xA5.
  - No rvalid on either requester.
- dbg_halt=1 with core_req=1 for 20 cycles, host idle:
  - core_gnt=0 throughout, wait_cnt=0.
  - After dbg_halt falls, core_gnt=1 in the same cycle.
- reset_n pulsed low in the cycle after a core read grant to 0x20:
  - mem_we and mem_adr go to 0 immediately.
  - No core_rvalid ever appears for that read.
  - After release, a new host read at 0x01 completes with host_rvalid 2 cycles after its grant.
- Back-to-back core reads 0x00..0x03, with mem returning 0x100+adr:
  - 4 consecutive grants.
  - core_rvalid high 4 consecutive cycles with rdata 0x100, 0x101, 0x102, 0x103, in order.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory-port arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned RDATA_W = 15;
    localparam int unsigned WDATA_W = 8;
    localparam int unsigned WAIT_W  = 4;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CORE,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive cycles the core was denied; asks for a forced core grant once saturated.
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic core_req,
    input  logic core_gnt,
    input  logic dbg_halt,
    output logic force_core
);

    localparam logic [WAIT_W-1:0] MaxCnt = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (!core_req || dbg_halt || core_gnt) begin
            wait_cnt <= '0;
        end else if (wait_cnt != MaxCnt) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign force_core = (wait_cnt == MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between the core and the host loader/debug port.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = mem_arb_pkg::ADDR_W,
    parameter int unsigned RDATA_W  = mem_arb_pkg::RDATA_W,
    parameter int unsigned WDATA_W  = mem_arb_pkg::WDATA_W,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               core_req,
    input  logic               core_we,
    input  logic [ADDR_W-1:0]  core_adr,
    input  logic [WDATA_W-1:0] core_wdata,
    output logic               core_gnt,
    output logic               core_rvalid,
    input  logic               host_req,
    input  logic               host_we,
    input  logic [ADDR_W-1:0]  host_adr,
    input  logic [WDATA_W-1:0] host_wdata,
    output logic               host_gnt,
    output logic               host_rvalid,
    input  logic               dbg_halt,
    output logic [RDATA_W-1:0] rdata,
    output logic [ADDR_W-1:0]  mem_adr,
    output logic               mem_we,
    output logic [WDATA_W-1:0] mem_wdata,
    input  logic [RDATA_W-1:0] mem_rdata
);

    logic   force_core;
    logic   core_ok;
    logic   core_win;
    logic   host_win;
    owner_t owner;
    logic   rd_valid;
    logic   rd_owner;  // 1 = host owns the read returning this cycle

    mem_arb_starve_ctr #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk       (clk),
        .reset_n   (reset_n),
        .core_req  (core_req),
        .core_gnt  (core_win),
        .dbg_halt  (dbg_halt),
        .force_core(force_core)
    );

    // Host has priority unless the core has been starved long enough; halt masks the core.
    assign core_ok  = core_req && !dbg_halt;
    assign core_win = reset_n && core_ok && (!host_req || force_core);
    assign host_win = reset_n && host_req && !core_win;

    assign core_gnt = core_win;
    assign host_gnt = host_win;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mem_adr   <= '0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            owner     <= OWN_NONE;
            rd_valid  <= 1'b0;
            rd_owner  <= 1'b0;
            rdata     <= '0;
        end else begin
            rdata    <= mem_rdata;
            rd_valid <= (owner != OWN_NONE) && !mem_we;
            rd_owner <= (owner == OWN_HOST);
            if (core_win) begin
                mem_adr   <= core_adr;
                mem_we    <= core_we;
                mem_wdata <= core_wdata;
                owner     <= OWN_CORE;
            end else if (host_win) begin
                mem_adr   <= host_adr;
                mem_we    <= host_we;
                mem_wdata <= host_wdata;
                owner     <= OWN_HOST;
            end else begin
                mem_we    <= 1'b0;
                owner     <= OWN_NONE;
            end
        end
    end

    assign core_rvalid = rd_valid && !rd_owner;
    assign host_rvalid = rd_valid && rd_owner;

endmodule
